// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module      : mem_arbiter
//  Description : Round-robin arbiter sharing one memory port between IFU and LSU.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int DATA_LEN = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [DATA_LEN-1:0]   ifu_addr,
    input  logic                  ifu_flush,
    output logic                  ifu_resp_valid,
    output logic [DATA_LEN-1:0]   ifu_rdata,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic                  lsu_wen,
    input  logic [DATA_LEN-1:0]   lsu_addr,
    input  logic [DATA_LEN-1:0]   lsu_wdata,
    input  logic [DATA_LEN/8-1:0] lsu_wmask,
    output logic                  lsu_resp_valid,
    output logic [DATA_LEN-1:0]   lsu_rdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_wen,
    output logic [DATA_LEN-1:0]   mem_addr,
    output logic [DATA_LEN-1:0]   mem_wdata,
    output logic [DATA_LEN/8-1:0] mem_wmask,
    input  logic                  mem_resp_valid,
    input  logic [DATA_LEN-1:0]   mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10
    } state_t;

    state_t r_state;
    logic   r_owner_lsu;
    logic   r_last_lsu;
    logic   r_drop;

    logic   w_grant_ifu;
    logic   w_grant_lsu;
    logic   w_flush_hit;

    // On a tie, the requester that was not granted last wins.
    always_comb begin
        w_grant_lsu = lsu_req_valid && (!ifu_req_valid || !r_last_lsu);
        w_grant_ifu = ifu_req_valid && !w_grant_lsu;
        w_flush_hit = ifu_flush && !r_owner_lsu && (r_state != S_IDLE);
    end

    // Readies are forced low while reset is held so every output reads 0.
    assign ifu_req_ready = rst_n && (r_state == S_IDLE) && w_grant_ifu;
    assign lsu_req_ready = rst_n && (r_state == S_IDLE) && w_grant_lsu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_owner_lsu    <= 1'b0;
            r_last_lsu     <= 1'b0;
            r_drop         <= 1'b0;
            ifu_resp_valid <= 1'b0;
            ifu_rdata      <= '0;
            lsu_resp_valid <= 1'b0;
            lsu_rdata      <= '0;
            mem_req_valid  <= 1'b0;
            mem_wen        <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_wmask      <= '0;
        end else begin
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_ifu) begin
                        r_owner_lsu   <= 1'b0;
                        r_last_lsu    <= 1'b0;
                        r_drop        <= 1'b0;
                        mem_req_valid <= 1'b1;
                        mem_wen       <= 1'b0;
                        mem_addr      <= ifu_addr;
                        mem_wdata     <= '0;
                        mem_wmask     <= '0;
                        r_state       <= S_REQ;
                    end else if (w_grant_lsu) begin
                        r_owner_lsu   <= 1'b1;
                        r_last_lsu    <= 1'b1;
                        r_drop        <= 1'b0;
                        mem_req_valid <= 1'b1;
                        mem_wen       <= lsu_wen;
                        mem_addr      <= lsu_addr;
                        mem_wdata     <= lsu_wdata;
                        mem_wmask     <= lsu_wmask;
                        r_state       <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (w_flush_hit) begin
                        r_drop <= 1'b1;
                    end
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        r_state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_flush_hit) begin
                        r_drop <= 1'b1;
                    end
                    if (mem_resp_valid) begin
                        if (!r_owner_lsu) begin
                            ifu_rdata      <= mem_rdata;
                            // A flush arriving with the response still suppresses it.
                            ifu_resp_valid <= !(r_drop || w_flush_hit);
                        end else begin
                            if (!mem_wen) begin
                                lsu_rdata <= mem_rdata;
                            end
                            lsu_resp_valid <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    mem_req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
